// File: rtl/branch_hazard_unit.sv
// branch_hazard_unit: ID-stage branch/JALR resolution with stall counting, EX forwarding selects, load-use stalls.
// Define BHT_PREDICT_EN to build the 2-bit BHT for fetch prediction; otherwise fetch uses static BTFN.
module branch_hazard_unit #(
   parameter int XLEN      = 32,
   parameter int RA_W      = 5,
   parameter int BHT_DEPTH = 64
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            dec_valid,
   input  logic            dec_is_branch,
   input  logic            dec_is_jalr,
   input  logic [2:0]      dec_funct3,
   input  logic [XLEN-1:0] dec_pc,
   input  logic [XLEN-1:0] dec_imm,
   input  logic [RA_W-1:0] dec_rs1,
   input  logic [RA_W-1:0] dec_rs2,
   input  logic            dec_pred_taken,
   input  logic [XLEN-1:0] rf_rdata1,
   input  logic [XLEN-1:0] rf_rdata2,
   input  logic [RA_W-1:0] ex_rd,
   input  logic            ex_wen,
   input  logic            ex_is_load,
   input  logic [RA_W-1:0] mem_rd,
   input  logic            mem_wen,
   input  logic            mem_is_load,
   input  logic [XLEN-1:0] mem_alu_res,
   input  logic [XLEN-1:0] mem_load_data,
   input  logic [RA_W-1:0] wb_rd,
   input  logic            wb_wen,
   input  logic [XLEN-1:0] wb_data,
   input  logic [XLEN-1:0] if_pc,
   input  logic            if_is_branch,
   input  logic            if_backward,
   output logic            if_pred_taken,
   output logic            stall,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic [1:0]      fwd_sel_a,
   output logic [1:0]      fwd_sel_b
);
   localparam int IW = $clog2(BHT_DEPTH);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic ex1, ex2, mem1, mem2, wb1, wb2, is_cf, stall_c, resolve, taken, eq, lt, ltu, bht_we;
   logic [1:0] w1, w2, need;
   logic [XLEN-1:0] op1, op2, jsum, target;
   assign ex1  = ex_wen  && ex_rd  != '0 && ex_rd  == dec_rs1;
   assign ex2  = ex_wen  && ex_rd  != '0 && ex_rd  == dec_rs2;
   assign mem1 = mem_wen && mem_rd != '0 && mem_rd == dec_rs1;
   assign mem2 = mem_wen && mem_rd != '0 && mem_rd == dec_rs2;
   assign wb1  = wb_wen  && wb_rd  != '0 && wb_rd  == dec_rs1;
   assign wb2  = wb_wen  && wb_rd  != '0 && wb_rd  == dec_rs2;
   assign is_cf = dec_is_branch || dec_is_jalr;
   // Cycles to wait until every operand is available from MEM ALU result, WB or the RF
   assign w1   = (ex1 && ex_is_load) ? 2'd2 : (ex1 || (mem1 && mem_is_load)) ? 2'd1 : 2'd0;
   assign w2   = (ex2 && ex_is_load) ? 2'd2 : (ex2 || (mem2 && mem_is_load)) ? 2'd1 : 2'd0;
   assign need = (w1 > w2) ? w1 : w2;
   assign op1 = (mem1 && !mem_is_load) ? mem_alu_res : wb1 ? wb_data : rf_rdata1;
   assign op2 = (mem2 && !mem_is_load) ? mem_alu_res : wb2 ? wb_data : rf_rdata2;
   assign eq  = op1 == op2;
   assign lt  = $signed(op1) < $signed(op2);
   assign ltu = op1 < op2;
   assign taken = dec_funct3 == 3'b000 ? eq  : dec_funct3 == 3'b001 ? !eq  :
                  dec_funct3 == 3'b100 ? lt  : dec_funct3 == 3'b101 ? !lt  :
                  dec_funct3 == 3'b110 ? ltu : dec_funct3 == 3'b111 ? !ltu : 1'b0;
   assign jsum   = op1 + dec_imm;
   assign target = dec_is_jalr ? {jsum[XLEN-1:1], 1'b0} : taken ? dec_pc + dec_imm : dec_pc + XLEN'(4);
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall_c = 1'b0;
      resolve = 1'b0;
      if (dec_valid && is_cf) begin
         if (state_q == IDLE) begin
            if (need != 2'd0) begin
               stall_c = 1'b1;
               cnt_d   = need - 2'd1;
               state_d = WAIT;
            end else resolve = 1'b1;
         end else if (cnt_q != 2'd0) begin
            stall_c = 1'b1;
            cnt_d   = cnt_q - 2'd1;
         end else begin
            resolve = 1'b1;
            state_d = IDLE;
         end
      end else begin
         state_d = IDLE;
         cnt_d   = 2'd0;
         stall_c = dec_valid && ex_is_load && (ex1 || ex2);
      end
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   // Outputs are forced to their reset values while rstn is low
   assign stall       = rstn && stall_c;
   assign redirect    = rstn && resolve && (dec_is_jalr || taken != dec_pred_taken);
   assign redirect_pc = redirect ? target : '0;
   assign fwd_sel_a   = (rstn && dec_valid && !is_cf) ? (ex1 ? 2'b01 : mem1 ? 2'b10 : 2'b00) : 2'b00;
   assign fwd_sel_b   = (rstn && dec_valid && !is_cf) ? (ex2 ? 2'b01 : mem2 ? 2'b10 : 2'b00) : 2'b00;
   assign bht_we      = resolve && dec_is_branch && !dec_is_jalr;
`ifdef BHT_PREDICT_EN
   logic [1:0] bht_q [BHT_DEPTH];
   logic [IW-1:0] wr_idx, rd_idx;
   assign wr_idx = dec_pc[IW+1:2];
   assign rd_idx = if_pc[IW+1:2];
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
      end else if (bht_we) begin
         bht_q[wr_idx] <= taken ? ((bht_q[wr_idx] == 2'b11) ? 2'b11 : bht_q[wr_idx] + 2'd1)
                                : ((bht_q[wr_idx] == 2'b00) ? 2'b00 : bht_q[wr_idx] - 2'd1);
      end
   end
   assign if_pred_taken = if_is_branch && bht_q[rd_idx][1];
`else
   assign if_pred_taken = if_is_branch && if_backward;
`endif
   logic unused;
   assign unused = ^{mem_load_data, if_pc, if_backward, bht_we};
endmodule

// File: tb/tb_branch_hazard_unit.sv
// tb_branch_hazard_unit: directed scenarios plus randomized traffic against a behavioural model.
// Honours BHT_PREDICT_EN the same way the design does.
module tb_branch_hazard_unit;
   logic clk = 1'b0, rstn = 1'b0;
   logic dec_valid, dec_is_branch, dec_is_jalr, dec_pred_taken;
   logic [2:0] dec_funct3;
   logic [31:0] dec_pc, dec_imm, rf_rdata1, rf_rdata2, mem_alu_res, mem_load_data, wb_data, if_pc;
   logic [4:0] dec_rs1, dec_rs2, ex_rd, mem_rd, wb_rd;
   logic ex_wen, ex_is_load, mem_wen, mem_is_load, wb_wen, if_is_branch, if_backward;
   logic if_pred_taken, stall, redirect;
   logic [31:0] redirect_pc;
   logic [1:0] fwd_sel_a, fwd_sel_b;
   int total = 0, passed = 0;
   int req = -1, age = 0, n_req, n_age;
   int bht [64];
   bit m_cf, m_resolve, m_taken;
   branch_hazard_unit dut (
      .clk(clk), .rstn(rstn), .dec_valid(dec_valid), .dec_is_branch(dec_is_branch),
      .dec_is_jalr(dec_is_jalr), .dec_funct3(dec_funct3), .dec_pc(dec_pc), .dec_imm(dec_imm),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_pred_taken(dec_pred_taken),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .ex_rd(ex_rd), .ex_wen(ex_wen),
      .ex_is_load(ex_is_load), .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
      .mem_alu_res(mem_alu_res), .mem_load_data(mem_load_data), .wb_rd(wb_rd), .wb_wen(wb_wen),
      .wb_data(wb_data), .if_pc(if_pc), .if_is_branch(if_is_branch), .if_backward(if_backward),
      .if_pred_taken(if_pred_taken), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask
   function automatic bit hit(input logic [4:0] rd, input logic wen, input logic [4:0] rs);
      return wen && rd != 0 && rd == rs;
   endfunction
   function automatic int wait_for(input logic [4:0] rs);
      if (hit(ex_rd, ex_wen, rs)) return ex_is_load ? 2 : 1;
      if (hit(mem_rd, mem_wen, rs) && mem_is_load) return 1;
      return 0;
   endfunction
   function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
      if (hit(mem_rd, mem_wen, rs) && !mem_is_load) return mem_alu_res;
      if (hit(wb_rd, wb_wen, rs)) return wb_data;
      return rf;
   endfunction
   function automatic logic [1:0] fsel(input logic [4:0] rs);
      if (hit(ex_rd, ex_wen, rs)) return 2'b01;
      if (hit(mem_rd, mem_wen, rs)) return 2'b10;
      return 2'b00;
   endfunction
   task automatic clear();
      {dec_valid, dec_is_branch, dec_is_jalr, dec_pred_taken, dec_funct3} = '0;
      {dec_pc, dec_imm, rf_rdata1, rf_rdata2, mem_alu_res, mem_load_data, wb_data, if_pc} = '0;
      {dec_rs1, dec_rs2, ex_rd, mem_rd, wb_rd} = '0;
      {ex_wen, ex_is_load, mem_wen, mem_is_load, wb_wen, if_is_branch, if_backward} = '0;
   endtask
   // Model outputs for the current inputs, compared against the DUT, then one clock
   task automatic cycle();
      logic [31:0] a, b, tgt;
      bit e_stall, e_red, e_pred;
      logic [1:0] e_fa, e_fb;
      int need;
      e_stall = 0; e_red = 0; tgt = 0; e_fa = 0; e_fb = 0; m_resolve = 0; m_taken = 0;
      if (!rstn) begin
         req = -1;
         foreach (bht[i]) bht[i] = 1;
      end
      m_cf = dec_valid && (dec_is_branch || dec_is_jalr);
      if (rstn && m_cf) begin
         need  = wait_for(dec_rs1) > wait_for(dec_rs2) ? wait_for(dec_rs1) : wait_for(dec_rs2);
         n_req = req < 0 ? need : req;
         n_age = req < 0 ? 0 : age;
         e_stall = n_age < n_req;
         m_resolve = n_age == n_req;
         a = operand(dec_rs1, rf_rdata1);
         b = operand(dec_rs2, rf_rdata2);
         case (dec_funct3)
            3'b000: m_taken = a == b;
            3'b001: m_taken = a != b;
            3'b100: m_taken = $signed(a) < $signed(b);
            3'b101: m_taken = $signed(a) >= $signed(b);
            3'b110: m_taken = a < b;
            3'b111: m_taken = a >= b;
            default: m_taken = 0;
         endcase
         if (m_resolve && dec_is_jalr) begin
            e_red = 1;
            tgt = (a + dec_imm) & 32'hFFFF_FFFE;
         end else if (m_resolve && m_taken != dec_pred_taken) begin
            e_red = 1;
            tgt = m_taken ? dec_pc + dec_imm : dec_pc + 4;
         end
      end else if (rstn && dec_valid) begin
         e_fa = fsel(dec_rs1);
         e_fb = fsel(dec_rs2);
         e_stall = ex_is_load && (hit(ex_rd, ex_wen, dec_rs1) || hit(ex_rd, ex_wen, dec_rs2));
      end
`ifdef BHT_PREDICT_EN
      e_pred = if_is_branch && bht[if_pc[7:2]] >= 2;
`else
      e_pred = if_is_branch && if_backward;
`endif
      chk("m_stall", stall, e_stall);
      chk("m_redirect", redirect, e_red);
      if (e_red) chk("m_redirect_pc", redirect_pc, tgt);
      chk("m_fwd_a", fwd_sel_a, e_fa);
      chk("m_fwd_b", fwd_sel_b, e_fb);
      chk("m_pred", if_pred_taken, e_pred);
      @(posedge clk);
      if (!rstn) req = -1;
      else if (m_cf) begin
         if (m_resolve) req = -1;
         else begin
            req = n_req;
            age = n_age + 1;
         end
         if (m_resolve && dec_is_branch && !dec_is_jalr)
            bht[dec_pc[7:2]] = m_taken ? (bht[dec_pc[7:2]] == 3 ? 3 : bht[dec_pc[7:2]] + 1)
                                       : (bht[dec_pc[7:2]] == 0 ? 0 : bht[dec_pc[7:2]] - 1);
      end else req = -1;
      @(negedge clk);
   endtask
   task automatic branch(input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2);
      clear();
      dec_valid = 1; dec_is_branch = 1; dec_funct3 = f3; dec_rs1 = r1; dec_rs2 = r2;
   endtask
   function automatic logic [31:0] rnd_data();
      logic [31:0] pool [4] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF};
      return $urandom_range(0, 2) != 0 ? pool[$urandom_range(0, 3)] : $urandom;
   endfunction
   initial begin
      clear();
      @(negedge clk);
      branch(3'b000, 1, 2);
      rf_rdata1 = 5; rf_rdata2 = 5; dec_pc = 32'h100; dec_imm = 32'h20;
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_redirect", redirect, 0);
      chk("rst_redirect_pc", redirect_pc, 0);
      chk("rst_fwd_a", fwd_sel_a, 0);
      cycle();
      rstn = 1;
      #1;
      chk("t1_redirect", redirect, 1);
      chk("t1_pc", redirect_pc, 32'h120);
      chk("t1_stall", stall, 0);
      cycle();
      branch(3'b001, 3, 0);
      ex_rd = 3; ex_wen = 1; ex_is_load = 1; rf_rdata1 = 32'h55;
      #1; chk("t2_stall0", stall, 1); cycle();
      {ex_rd, ex_wen, ex_is_load} = '0; mem_rd = 3; mem_wen = 1; mem_is_load = 1;
      #1; chk("t2_stall1", stall, 1); cycle();
      {mem_rd, mem_wen, mem_is_load} = '0; wb_rd = 3; wb_wen = 1; wb_data = 0;
      #1; chk("t2_stall2", stall, 0); chk("t2_redirect", redirect, 0); cycle();
      clear();
      dec_valid = 1; dec_is_jalr = 1; dec_rs1 = 4; dec_imm = 3; rf_rdata1 = 32'h7000;
      ex_rd = 4; ex_wen = 1;
      #1; chk("t3_stall", stall, 1); chk("t3_redirect0", redirect, 0); cycle();
      {ex_rd, ex_wen} = '0; mem_rd = 4; mem_wen = 1; mem_alu_res = 32'h2001;
      #1; chk("t3_redirect", redirect, 1); chk("t3_pc", redirect_pc, 32'h2004); chk("t3_stall1", stall, 0);
      cycle();
      clear();
      dec_valid = 1; dec_rs1 = 5; dec_rs2 = 6; ex_rd = 5; ex_wen = 1; ex_is_load = 1;
      #1; chk("t4_lu_stall", stall, 1); chk("t4_lu_fwd", fwd_sel_a, 2'b01); cycle();
      {ex_rd, ex_wen, ex_is_load} = '0; mem_rd = 5; mem_wen = 1;
      #1; chk("t4_mem_stall", stall, 0); chk("t4_mem_fwd", fwd_sel_a, 2'b10); cycle();
      ex_rd = 5; ex_wen = 1;
      #1; chk("t4_both_fwd", fwd_sel_a, 2'b01); cycle();
      ex_rd = 0; mem_rd = 6; dec_rs1 = 0;
      #1; chk("t4_x0_fwd", fwd_sel_a, 2'b00); chk("t4_b_fwd", fwd_sel_b, 2'b10); cycle();
      for (int i = 0; i < 4; i++) begin
         branch(3'b000, 1, 2);
         rf_rdata1 = 7; rf_rdata2 = i < 3 ? 7 : 8; dec_pc = 32'h40; dec_imm = 32'h10;
         dec_pred_taken = 1; if_pc = 32'h40; if_is_branch = 1; if_backward = i[0];
         #1;
`ifdef BHT_PREDICT_EN
         chk("t5_pred", if_pred_taken, i > 0);
`else
         chk("t5_btfn", if_pred_taken, i[0]);
`endif
         cycle();
      end
      if_backward = 0;
      #1;
`ifdef BHT_PREDICT_EN
      chk("t5_pred_after_nt", if_pred_taken, 1);
`else
      chk("t5_btfn_fwd", if_pred_taken, 0);
`endif
      branch(3'b000, 1, 2);
      rf_rdata1 = 1; rf_rdata2 = 1; dec_pc = 32'h40; dec_imm = 32'h10; if_pc = 32'h40; if_is_branch = 1;
      ex_rd = 1; ex_wen = 1; ex_is_load = 1;
      #1; chk("t6_drop_stall0", stall, 1); cycle();
      dec_valid = 0;
      #1; chk("t6_drop_stall", stall, 0); chk("t6_drop_redirect", redirect, 0); cycle();
      branch(3'b000, 1, 2);
      rf_rdata1 = 1; rf_rdata2 = 1; dec_pc = 32'h80; dec_imm = 32'h8; if_pc = 32'h40; if_is_branch = 1;
      #1;
      chk("t6_idle_redirect", redirect, 1);
      chk("t6_idle_pc", redirect_pc, 32'h88);
`ifdef BHT_PREDICT_EN
      chk("t6_bht_kept", if_pred_taken, 1);
`endif
      cycle();
      branch(3'b001, 2, 0);
      ex_rd = 2; ex_wen = 1; ex_is_load = 1;
      #1; chk("t6_wait_stall", stall, 1); cycle();
      {ex_rd, ex_wen, ex_is_load} = '0;
      rstn = 0;
      #1; chk("t6_rst_stall", stall, 0); chk("t6_rst_redirect", redirect, 0); cycle();
      rstn = 1;
      clear();
      cycle();
      for (int n = 0; n < 2000; n++) begin
         if (!(stall && $urandom_range(0, 3) != 0)) begin
            int kind = $urandom_range(0, 7);
            dec_valid = $urandom_range(0, 9) != 0;
            dec_is_branch = kind < 3;
            dec_is_jalr = kind == 3;
            dec_funct3 = 3'($urandom_range(0, 7));
            dec_pc = 32'h1000 + 4 * $urandom_range(0, 7);
            dec_imm = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 64)) - 32;
            dec_rs1 = 5'($urandom_range(0, 3));
            dec_rs2 = 5'($urandom_range(0, 3));
            dec_pred_taken = 1'($urandom_range(0, 1));
            rf_rdata1 = rnd_data();
            rf_rdata2 = rnd_data();
         end
         ex_rd = 5'($urandom_range(0, 3)); ex_wen = 1'($urandom); ex_is_load = 1'($urandom);
         mem_rd = 5'($urandom_range(0, 3)); mem_wen = 1'($urandom); mem_is_load = 1'($urandom);
         wb_rd = 5'($urandom_range(0, 3)); wb_wen = 1'($urandom);
         mem_alu_res = rnd_data(); mem_load_data = rnd_data(); wb_data = rnd_data();
         if_pc = 32'h1000 + 4 * $urandom_range(0, 7);
         if_is_branch = 1'($urandom); if_backward = 1'($urandom);
         #1;
         cycle();
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
